// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Consumer end of the fetch_data_t stream. Accepts
//            {instruction, pc} on a valid/ready handshake, decodes the
//            instruction combinationally, and holds the result in a
//            two-entry buffer (main + skid). The main entry drives the
//            registered decode bundle presented to execute. A flush
//            discards every held and incoming instruction.
// Ports    : clk          - single clock, all state on the rising edge
//            reset        - synchronous, active-low (0 = reset)
//            in_valid     - fetch presents a fetch_data_t
//            in_data      - {instruction[63:32], pc[31:0]}
//            in_ready     - decode_stage can take in_data this cycle
//            flush        - discard held and incoming instructions
//            out_valid    - decode bundle valid
//            out_ready    - execute accepts the bundle
//            out_op       - NOP=0 ADD=1 SUB=2 AND=3 OR=4 SLT=5 ADDI=6
//                           LW=7 SW=8 J=9 BEQ=10 ILL=15
//            out_pc       - pc of the decoded instruction
//            out_rs/rt    - instr[25:21] / instr[20:16]
//            out_dst      - destination register (0 when nothing written)
//            out_imm      - sign-extended instr[15:0]
//            out_jtarget  - {pc_plus4[31:28], instr[25:0], 2'b00}
//            out_regwr/out_memrd/out_memwr - control bits
//            out_illegal  - illegal-instruction trap flag
// Config   : DECODE_ILLEGAL_TRAP_EN - when defined, illegal encodings are
//            decoded as ILL with out_illegal=1 and the input is stalled
//            while an ILL bundle sits in the main entry. When undefined,
//            illegal encodings decode as NOP and out_illegal is always 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_dst,
    output logic [31:0] out_imm,
    output logic [31:0] out_jtarget,
    output logic        out_regwr,
    output logic        out_memrd,
    output logic        out_memwr,
    output logic        out_illegal
);

    // ------------------------------------------------------------------
    // Operation codes presented on out_op
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [3:0] OP_ILL  = 4'd15;
`endif

    // Instruction opcode field values
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    // R-type funct field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [31:0] jtarget;
        logic        regwr;
        logic        memrd;
        logic        memwr;
        logic        illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming fetch data
    // ------------------------------------------------------------------
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [5:0]  dec_opcode;
    logic [5:0]  dec_funct;
    logic [3:0]  dec_pc_plus4_hi;
    logic        dec_is_ill;
    bundle_t     dec;

    assign dec_instr  = in_data[63:32];
    assign dec_pc     = in_data[31:0];
    assign dec_opcode = dec_instr[31:26];
    assign dec_funct  = dec_instr[5:0];

    // Only the top nibble of pc+4 is needed: it carries out of bit 27
    // exactly when pc[27:2] is all ones. Wraps naturally modulo 2^32.
    assign dec_pc_plus4_hi = dec_pc[31:28] + {3'b000, &dec_pc[27:2]};

    always_comb begin
        dec            = '0;
        dec_is_ill     = 1'b0;
        dec.pc         = dec_pc;
        dec.rs         = dec_instr[25:21];
        dec.rt         = dec_instr[20:16];
        dec.imm        = {{16{dec_instr[15]}}, dec_instr[15:0]};
        dec.jtarget    = {dec_pc_plus4_hi, dec_instr[25:0], 2'b00};

        // Operation selection
        if (dec_instr == 32'h0000_0000) begin
            dec.op = OP_NOP;
        end else begin
            case (dec_opcode)
                OPC_RTYPE: begin
                    case (dec_funct)
                        FN_ADD:  dec.op = OP_ADD;
                        FN_SUB:  dec.op = OP_SUB;
                        FN_AND:  dec.op = OP_AND;
                        FN_OR:   dec.op = OP_OR;
                        FN_SLT:  dec.op = OP_SLT;
                        default: dec_is_ill = 1'b1;
                    endcase
                end
                OPC_ADDI: dec.op = OP_ADDI;
                OPC_LW:   dec.op = OP_LW;
                OPC_SW:   dec.op = OP_SW;
                OPC_J:    dec.op = OP_J;
                OPC_BEQ:  dec.op = OP_BEQ;
                default:  dec_is_ill = 1'b1;
            endcase
        end

        // Control bits and destination follow from the selected operation.
        // A destination of r0 still asserts regwr; the register file drops it.
        case (dec.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                dec.regwr = 1'b1;
                dec.dst   = dec_instr[15:11];
            end
            OP_ADDI: begin
                dec.regwr = 1'b1;
                dec.dst   = dec_instr[20:16];
            end
            OP_LW: begin
                dec.regwr = 1'b1;
                dec.memrd = 1'b1;
                dec.dst   = dec_instr[20:16];
            end
            OP_SW: begin
                dec.memwr = 1'b1;
            end
            default: begin
                dec.regwr = 1'b0;
            end
        endcase

        // Illegal encodings: op stays NOP with all control bits clear unless
        // the trap is built in, in which case the bundle is tagged ILL.
        if (dec_is_ill) begin
            dec.op    = OP_NOP;
            dec.regwr = 1'b0;
            dec.memrd = 1'b0;
            dec.memwr = 1'b0;
            dec.dst   = 5'd0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec.op      = OP_ILL;
            dec.illegal = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Two-entry buffer: main drives the outputs, skid catches the one
    // transfer that can land while main is stalled.
    // ------------------------------------------------------------------
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;

    logic    trap_stall;
    logic    accept;
    logic    consume;

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Serialise the stream behind an ILL bundle until execute takes it.
    assign trap_stall = main_valid_q && main_q.illegal;
`else
    assign trap_stall = 1'b0;
`endif

    // in_ready depends only on registered state plus the flush override.
    assign in_ready = !skid_valid_q && !flush && !trap_stall;
    assign accept   = in_valid && in_ready;
    assign consume  = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (flush) begin
            // Payload is left untouched so outputs hold their last value.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            if (skid_valid_q) begin
                // in_ready was low, so no input can arrive this cycle.
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_d       = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            main_q.pc    <= RESET_PC;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Output bundle
    // ------------------------------------------------------------------
    assign out_valid   = main_valid_q;
    assign out_op      = main_q.op;
    assign out_pc      = main_q.pc;
    assign out_rs      = main_q.rs;
    assign out_rt      = main_q.rt;
    assign out_dst     = main_q.dst;
    assign out_imm     = main_q.imm;
    assign out_jtarget = main_q.jtarget;
    assign out_regwr   = main_q.regwr;
    assign out_memrd   = main_q.memrd;
    assign out_memwr   = main_q.memwr;
    // Without the trap the illegal field is never set, so this stays 0.
    assign out_illegal = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. A queue-based model of
//            the two-deep buffer and a rule-based decoder predict outputs
//            every cycle; directed vectors pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam int ILL_OP = 15;
    localparam bit TRAP   = 1'b1;
`else
    localparam int ILL_OP = 0;
    localparam bit TRAP   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op;
    logic [31:0] out_pc;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_dst;
    logic [31:0] out_imm;
    logic [31:0] out_jtarget;
    logic        out_regwr;
    logic        out_memrd;
    logic        out_memwr;
    logic        out_illegal;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
        .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
        .out_imm(out_imm), .out_jtarget(out_jtarget), .out_regwr(out_regwr),
        .out_memrd(out_memrd), .out_memwr(out_memwr), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          op;
        logic [31:0] pc;
        int          rs, rt, dst;
        logic [31:0] imm, jt;
        bit          regwr, memrd, memwr, ill;
    } exp_t;

    function automatic exp_t model_dec(input logic [63:0] d);
        exp_t        e;
        logic [31:0] ins;
        int          opc, fn;
        ins   = d[63:32];
        e.pc  = d[31:0];
        opc   = int'(ins >> 26);
        fn    = int'(ins & 32'h3F);
        e.rs  = int'((ins >> 21) & 32'h1F);
        e.rt  = int'((ins >> 16) & 32'h1F);
        e.imm = (ins & 32'h8000) != 0 ? (ins | 32'hFFFF_0000) : (ins & 32'h0000_FFFF);
        e.jt  = ((e.pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (ins == 0)       e.op = 0;
        else if (opc == 0)  e.op = fn == 32 ? 1 : fn == 34 ? 2 : fn == 36 ? 3 :
                                   fn == 37 ? 4 : fn == 42 ? 5 : 15;
        else                e.op = opc == 8 ? 6 : opc == 35 ? 7 : opc == 43 ? 8 :
                                   opc == 2 ? 9 : opc == 4 ? 10 : 15;
        e.ill = (e.op == 15) && TRAP;
        if (e.op == 15) e.op = ILL_OP;
        e.regwr = (e.op >= 1 && e.op <= 7);
        e.memrd = (e.op == 7);
        e.memwr = (e.op == 8);
        if (e.op >= 1 && e.op <= 5)      e.dst = int'((ins >> 11) & 32'h1F);
        else if (e.op == 6 || e.op == 7) e.dst = e.rt;
        else                             e.dst = 0;
        return e;
    endfunction

    exp_t q[$];
    bit   started   = 1'b0;
    bit   rst_state = 1'b0;

    function automatic bit exp_rdy();
        if (flush) return 1'b0;
        if (q.size() >= 2) return 1'b0;
        if (q.size() > 0 && q[0].ill) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        bit cons;
        if (!reset) begin
            q.delete();
            started   = 1'b1;
            rst_state = 1'b1;
        end else begin
            rst_state = 1'b0;
            if (started) begin
                rdy  = exp_rdy();
                cons = out_ready && (q.size() > 0);
                if (flush) q.delete();
                else begin
                    if (cons) void'(q.pop_front());
                    if (in_valid && rdy) q.push_back(model_dec(in_data));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    bit          rec_en = 1'b0;
    logic [31:0] rec_q[$];

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy()});
            if (rst_state) begin
                chk("rst_pc", out_pc, RST_PC);
                chk("rst_op", {28'b0, out_op}, 32'd0);
                chk("rst_ctl", {29'b0, out_regwr, out_memrd, out_memwr}, 32'd0);
            end
            if (q.size() > 0) begin
                chk("op", {28'b0, out_op}, q[0].op);
                chk("pc", out_pc, q[0].pc);
                chk("rs", {27'b0, out_rs}, q[0].rs);
                chk("rt", {27'b0, out_rt}, q[0].rt);
                chk("dst", {27'b0, out_dst}, q[0].dst);
                chk("imm", out_imm, q[0].imm);
                chk("jtarget", out_jtarget, q[0].jt);
                chk("ctl", {28'b0, out_regwr, out_memrd, out_memwr, out_illegal},
                    {28'b0, q[0].regwr, q[0].memrd, q[0].memwr, q[0].ill});
            end
            if (rec_en && out_valid && out_ready) rec_q.push_back(out_pc);
        end
    end

    // ------------------------------------------------------------------
    // Directed literal vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins, pc;
        int          op, rs, rt, dst;
        logic [31:0] imm, jt;
        bit          chk_jt;
        bit          regwr, memrd, memwr, ill;
    } lit_t;

    lit_t lit[16];

    function automatic lit_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input int op, input int rs, input int rt, input int dst,
                                input logic [31:0] imm, input logic [31:0] jt, input bit cj,
                                input bit rw, input bit mr, input bit mw, input bit il);
        lit_t l;
        l.ins = ins; l.pc = pc; l.op = op; l.rs = rs; l.rt = rt; l.dst = dst;
        l.imm = imm; l.jt = jt; l.chk_jt = cj;
        l.regwr = rw; l.memrd = mr; l.memwr = mw; l.ill = il;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one transfer and hold it until the handshake, bounded.
    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        in_valid = 1'b1;
        in_data  = {ins, pc};
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) begin
            n_chk++;
            n_err++;
            $display("FAIL push_timeout: got in_ready=0 expected handshake for pc %h", pc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lit[0]  = mk(32'h00221820, 32'h40, 1, 1, 2, 3, 32'h1820, 0, 0, 1, 0, 0, 0);
        lit[1]  = mk(32'h2005FFFC, 32'h44, 6, 0, 5, 5, 32'hFFFFFFFC, 0, 0, 1, 0, 0, 0);
        lit[2]  = mk(32'h8C240008, 32'h48, 7, 1, 4, 4, 32'h8, 0, 0, 1, 1, 0, 0);
        lit[3]  = mk(32'hAC240008, 32'h4C, 8, 1, 4, 0, 32'h8, 0, 0, 0, 0, 1, 0);
        lit[4]  = mk(32'h08000040, 32'h10, 9, 0, 0, 0, 32'h40, 32'h100, 1, 0, 0, 0, 0);
        lit[5]  = mk(32'h10220003, 32'h14, 10, 1, 2, 0, 32'h3, 0, 0, 0, 0, 0, 0);
        lit[6]  = mk(32'h00221822, 32'h18, 2, 1, 2, 3, 32'h1822, 0, 0, 1, 0, 0, 0);
        lit[7]  = mk(32'h00221824, 32'h1C, 3, 1, 2, 3, 32'h1824, 0, 0, 1, 0, 0, 0);
        lit[8]  = mk(32'h00221825, 32'h20, 4, 1, 2, 3, 32'h1825, 0, 0, 1, 0, 0, 0);
        lit[9]  = mk(32'h0022182A, 32'h24, 5, 1, 2, 3, 32'h182A, 0, 0, 1, 0, 0, 0);
        lit[10] = mk(32'h00220020, 32'h2C, 1, 1, 2, 0, 32'h20, 0, 0, 1, 0, 0, 0);
        lit[11] = mk(32'h00000000, 32'h30, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        lit[12] = mk(32'hFC000000, 32'h34, ILL_OP, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, TRAP);
        lit[13] = mk(32'h00000001, 32'h38, ILL_OP, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0, TRAP);
        lit[14] = mk(32'h08000001, 32'hFFFFFFFC, 9, 0, 0, 0, 32'h1, 32'h4, 1, 0, 0, 0, 0);
        lit[15] = mk(32'h0BFFFFFF, 32'hEFFFFFFC, 9, 31, 31, 0, 32'hFFFFFFFF, 32'hFFFFFFFC, 1, 0, 0, 0, 0);

        // Reset held for two cycles
        tick();
        tick();
        @(negedge clk);
        chk("lit_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("lit_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("lit_rst_pc", out_pc, RST_PC);
        tick();
        reset = 1'b1;

        // Single transfers with execute always ready: 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(lit[i].ins, lit[i].pc);
            @(negedge clk);
            chk("lit_valid", {31'b0, out_valid}, 32'd1);
            chk("lit_op", {28'b0, out_op}, lit[i].op);
            chk("lit_pc", out_pc, lit[i].pc);
            chk("lit_rs", {27'b0, out_rs}, lit[i].rs);
            chk("lit_rt", {27'b0, out_rt}, lit[i].rt);
            chk("lit_dst", {27'b0, out_dst}, lit[i].dst);
            chk("lit_imm", out_imm, lit[i].imm);
            if (lit[i].chk_jt) chk("lit_jtarget", out_jtarget, lit[i].jt);
            chk("lit_ctl", {28'b0, out_regwr, out_memrd, out_memwr, out_illegal},
                {28'b0, lit[i].regwr, lit[i].memrd, lit[i].memwr, lit[i].ill});
            tick();
        end

        // Back-pressure: four transfers, execute stalled for a while
        out_ready = 1'b0;
        rec_q.delete();
        rec_en = 1'b1;
        fork
            begin
                repeat (6) tick();
                out_ready = 1'b1;
            end
        join_none
        push(32'h00221820, 32'h100);
        push(32'h2005FFFC, 32'h104);
        @(negedge clk);
        chk("lit_bp_ready", {31'b0, in_ready}, 32'd0);
        chk("lit_bp_valid", {31'b0, out_valid}, 32'd1);
        chk("lit_bp_head", out_pc, 32'h100);
        tick();
        push(32'h8C240008, 32'h108);
        push(32'hAC240008, 32'h10C);
        repeat (8) tick();
        rec_en = 1'b0;
        chk("lit_bp_count", rec_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("lit_bp_order", (i < rec_q.size()) ? rec_q[i] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * i));

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        push(32'h00221825, 32'h180);
        push(32'h0022182A, 32'h184);
        in_valid = 1'b1;
        in_data  = {32'h00221822, 32'h188};
        flush    = 1'b1;
        @(negedge clk);
        chk("lit_flush_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_flush_valid", {31'b0, out_valid}, 32'd0);
        tick();
        out_ready = 1'b1;
        push(32'h10220003, 32'h200);
        @(negedge clk);
        chk("lit_post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("lit_post_flush_pc", out_pc, 32'h200);
        chk("lit_post_flush_op", {28'b0, out_op}, 32'd10);
        tick();

        // Mixed traffic: irregular valid/ready with flushes, including a
        // flush in a cycle where execute also consumes.
        for (int i = 0; i < 60; i++) begin
            in_valid  = (i % 5) != 2;
            in_data   = {lit[i % 16].ins, 32'h1000 + 32'(4 * i)};
            out_ready = (i % 3) != 0;
            flush     = (i == 23) || (i == 41);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset during operation drops held entries
        out_ready = 1'b0;
        push(32'h00221820, 32'h300);
        push(32'h00221824, 32'h304);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("lit_rerst_valid", {31'b0, out_valid}, 32'd0);
        chk("lit_rerst_ready", {31'b0, in_ready}, 32'd1);
        chk("lit_rerst_pc", out_pc, RST_PC);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
